// File: rtl/rv32i_types.sv
// Shared pipeline types.
// mem_stall_state_t : pending-access state of the memory stall unit.
// stall_debug       : packed snapshot of stall-unit status for debug taps.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BOTH = 2'd1,
    WAIT_I    = 2'd2,
    WAIT_D    = 2'd3
  } mem_stall_state_t;

  typedef struct packed {
    logic             stall;
    logic             i_done;
    logic             d_done;
    mem_stall_state_t state;
  } stall_debug;

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;
  localparam int          PORT_I        = 0;
  localparam int          PORT_D        = 1;

endpackage

// File: rtl/mem_stall_unit.sv
// Memory stall unit: freezes the pipeline while an instruction fetch and/or
// data access is outstanding, remembers responses that arrive early so the
// completed access is not re-issued, and counts stalled cycles.
//
// State table
//   state     | meaning
//   IDLE      | no access pending
//   WAIT_BOTH | fetch and data access both outstanding
//   WAIT_I    | only the fetch outstanding
//   WAIT_D    | only the data access outstanding
//
// Ports
//   clk, rst                          clock, async active-high reset
//   imem_read, imem_resp, imem_rdata  IF request / I-cache response
//   dmem_read, dmem_write, dmem_resp,
//   dmem_rdata                        MEM request / D-cache response
//   imem_read_o, dmem_read_o,
//   dmem_write_o                      requests forwarded to the caches
//   instr_o, load_data_o              data delivered to IF/ID and MEM/WB
//   stall_pipeline                    freeze request to hazard unit
//   stall_cycles                      saturating count of stalled cycles
module mem_stall_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        imem_read_o,
  output logic        dmem_read_o,
  output logic        dmem_write_o,
  output logic [31:0] instr_o,
  output logic [31:0] load_data_o,
  output logic        stall_pipeline,
  output logic [31:0] stall_cycles
);

  // index 0 = fetch side, index 1 = data side
  logic [1:0]       req;
  logic [1:0]       resp;
  logic [1:0]       done_q;
  logic [1:0]       pending;
  logic [1:0]       capture;
  logic [31:0]      rdata  [2];
  logic [31:0]      hold_q [2];
  logic [31:0]      stall_cnt_q;
  logic             i_done;
  logic             d_done;
  mem_stall_state_t state_q;
  mem_stall_state_t state_d;

  assign req[PORT_I]   = imem_read;
  assign req[PORT_D]   = dmem_read | dmem_write;
  assign resp[PORT_I]  = imem_resp;
  assign resp[PORT_D]  = dmem_resp;
  assign rdata[PORT_I] = imem_rdata;
  assign rdata[PORT_D] = dmem_rdata;

  assign i_done = done_q[PORT_I];
  assign d_done = done_q[PORT_D];

  // Still outstanding once this cycle's responses are accounted for.
  assign pending        = req & ~done_q & ~resp;
  assign stall_pipeline = |pending;

  // Only an early response (the other side still pending) needs holding;
  // a final response is consumed directly as the pipeline advances.
  assign capture = {2{stall_pipeline}} & req & ~done_q & resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        done_q[k] <= 1'b0;
        hold_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!stall_pipeline) begin
          done_q[k] <= 1'b0;
        end else if (capture[k]) begin
          done_q[k] <= 1'b1;
          hold_q[k] <= rdata[k];
        end
      end
    end
  end

  assign imem_read_o  = imem_read  & ~i_done;
  assign dmem_read_o  = dmem_read  & ~d_done;
  assign dmem_write_o = dmem_write & ~d_done;
  assign instr_o      = i_done ? hold_q[PORT_I] : imem_rdata;
  assign load_data_o  = d_done ? hold_q[PORT_D] : dmem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_pipeline && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (stall_pipeline) begin
      case (pending)
        2'b11:   state_d = WAIT_BOTH;
        2'b01:   state_d = WAIT_I;
        2'b10:   state_d = WAIT_D;
        default: state_d = IDLE;
      endcase
    end
  end

  // IDLE is only ever entered on an advancing cycle or reset, both of which
  // clear the done flags.
  a_idle_flags_clear : assert property (
    @(posedge clk) disable iff (rst) (state_q == IDLE) |-> (done_q == 2'b00)
  );

endmodule

// File: tb/tb_mem_stall_unit.sv
module tb_mem_stall_unit;
  import rv32i_types::*;

  localparam logic [31:0] G = 32'hBAD0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_read = 1'b0, imem_resp = 1'b0;
  logic [31:0] imem_rdata = G;
  logic        dmem_read = 1'b0, dmem_write = 1'b0, dmem_resp = 1'b0;
  logic [31:0] dmem_rdata = G;
  logic        imem_read_o, dmem_read_o, dmem_write_o, stall_pipeline;
  logic [31:0] instr_o, load_data_o, stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stall_unit dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata),
    .imem_read_o(imem_read_o), .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
    .instr_o(instr_o), .load_data_o(load_data_o),
    .stall_pipeline(stall_pipeline), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per stall episode, which side has already answered
  // and what it returned; plus a saturating stall counter.
  bit          got_i = 0, got_d = 0;
  logic [31:0] ins_h = '0, ld_h = '0;
  logic [31:0] m_cnt = '0;
  bit          preload = 0;

  logic e_want_i, e_want_d, e_stall;
  assign e_want_i = imem_read & ~got_i;
  assign e_want_d = (dmem_read | dmem_write) & ~got_d;
  assign e_stall  = (e_want_i & ~imem_resp) | (e_want_d & ~dmem_resp);

  always @(posedge clk or posedge rst) begin : model
    logic        st, wi, wd;
    logic [31:0] base;
    if (rst) begin
      got_i = 0; got_d = 0; ins_h = '0; ld_h = '0; m_cnt = '0;
    end else begin
      st = e_stall; wi = e_want_i; wd = e_want_d;
      base = preload ? 32'hFFFF_FFFE : m_cnt;
      if (st) begin
        if (wi && imem_resp) begin got_i = 1; ins_h = imem_rdata; end
        if (wd && dmem_resp) begin got_d = 1; ld_h = dmem_rdata; end
        m_cnt = (base == 32'hFFFF_FFFF) ? base : base + 32'd1;
      end else begin
        got_i = 0; got_d = 0;
        m_cnt = base;
      end
    end
  end

  always @(negedge clk) begin
    chk("stall_pipeline", {31'd0, stall_pipeline}, {31'd0, e_stall});
    chk("imem_read_o",    {31'd0, imem_read_o},    {31'd0, e_want_i});
    chk("dmem_read_o",    {31'd0, dmem_read_o},    {31'd0, dmem_read & ~got_d});
    chk("dmem_write_o",   {31'd0, dmem_write_o},   {31'd0, dmem_write & ~got_d});
    chk("instr_o",        instr_o,     got_i ? ins_h : imem_rdata);
    chk("load_data_o",    load_data_o, got_d ? ld_h : dmem_rdata);
    chk("stall_cycles",   stall_cycles, m_cnt);
  end

  task automatic drv(input logic ir, input logic ires, input logic [31:0] id,
                     input logic dr, input logic dw, input logic dres, input logic [31:0] dd);
    imem_read = ir; imem_resp = ires; imem_rdata = id;
    dmem_read = dr; dmem_write = dw; dmem_resp = dres; dmem_rdata = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    tick();
    drv(0, 0, G, 0, 0, 0, G);
    @(negedge clk);
  endtask

  initial begin
    // reset state
    drv(0, 0, G, 0, 0, 0, G);
    @(negedge clk);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_stall", {31'd0, stall_pipeline}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);

    // fetch only: response on cycle 3
    for (int c = 0; c < 4; c++) begin
      tick();
      drv(1, c == 3, (c == 3) ? 32'h00A00093 : G, 0, 0, 0, G);
      @(negedge clk);
      if (c < 3) chk("t1_stall", {31'd0, stall_pipeline}, 32'd1);
      else begin
        chk("t1_stall_drop", {31'd0, stall_pipeline}, 32'd0);
        chk("t1_instr", instr_o, 32'h00A00093);
      end
    end
    idle_cycle();
    chk("t1_count", stall_cycles, 32'd3);

    // fetch answers first, load answers on cycle 4
    for (int c = 0; c < 5; c++) begin
      tick();
      drv(1, c == 1, (c == 1) ? 32'h12345678 : G, 1, 0, c == 4, (c == 4) ? 32'hDEADBEEF : G);
      @(negedge clk);
      if (c >= 2) chk("t2_imem_read_o", {31'd0, imem_read_o}, 32'd0);
      if (c >= 1) chk("t2_instr_hold", instr_o, 32'h12345678);
      chk("t2_stall", {31'd0, stall_pipeline}, (c < 4) ? 32'd1 : 32'd0);
      if (c == 4) chk("t2_load", load_data_o, 32'hDEADBEEF);
    end
    idle_cycle();
    chk("t2_count", stall_cycles, 32'd7);

    // store answers first (cycle 2), fetch on cycle 5
    for (int c = 0; c < 6; c++) begin
      tick();
      drv(1, c == 5, (c == 5) ? 32'hCAFE0001 : G, 0, 1, c == 2, G);
      @(negedge clk);
      if (c >= 3) chk("t3_dmem_write_o", {31'd0, dmem_write_o}, 32'd0);
      if (c == 1) chk("t3_state_both", 32'(dut.state_q), 32'(WAIT_BOTH));
      if (c == 3) chk("t3_state_i", 32'(dut.state_q), 32'(WAIT_I));
      chk("t3_stall", {31'd0, stall_pipeline}, (c < 5) ? 32'd1 : 32'd0);
    end
    idle_cycle();
    chk("t3_count", stall_cycles, 32'd12);

    // simultaneous responses on cycle 2
    for (int c = 0; c < 3; c++) begin
      tick();
      drv(1, c == 2, (c == 2) ? 32'h11111111 : G, 1, 0, c == 2, (c == 2) ? 32'h22222222 : G);
      @(negedge clk);
      if (c == 2) begin
        chk("t4_stall", {31'd0, stall_pipeline}, 32'd0);
        chk("t4_instr", instr_o, 32'h11111111);
        chk("t4_load", load_data_o, 32'h22222222);
      end
    end
    idle_cycle();
    chk("t4_i_done", {31'd0, dut.i_done}, 32'd0);
    chk("t4_d_done", {31'd0, dut.d_done}, 32'd0);
    chk("t4_count", stall_cycles, 32'd14);

    // reset mid-access after an early fetch response
    tick(); drv(1, 0, G, 1, 0, 0, G); @(negedge clk);
    tick(); drv(1, 1, 32'h0A0A0A0A, 1, 0, 0, G); @(negedge clk);
    tick(); drv(1, 0, G, 1, 0, 0, G); @(negedge clk);
    chk("t5_pre_i_done", {31'd0, dut.i_done}, 32'd1);
    tick(); rst = 1'b1; @(negedge clk);
    chk("t5_i_done", {31'd0, dut.i_done}, 32'd0);
    chk("t5_count", stall_cycles, 32'd0);
    chk("t5_reissue", {31'd0, imem_read_o}, 32'd1);
    tick(); rst = 1'b0; @(negedge clk);
    chk("t5_count_held", stall_cycles, 32'd0);
    tick(); drv(1, 1, 32'h0B0B0B0B, 1, 0, 1, 32'h0C0C0C0C); @(negedge clk);
    chk("t5_stall_drop", {31'd0, stall_pipeline}, 32'd0);
    idle_cycle();
    chk("t5_count_after", stall_cycles, 32'd1);

    // responses with no matching request are ignored
    tick(); drv(0, 1, 32'h33333333, 0, 0, 1, 32'h44444444); @(negedge clk);
    chk("t6_stall", {31'd0, stall_pipeline}, 32'd0);
    tick(); drv(1, 0, G, 0, 0, 1, 32'h55555555); @(negedge clk);
    chk("t6_i_done", {31'd0, dut.i_done}, 32'd0);
    chk("t6_stall_fetch", {31'd0, stall_pipeline}, 32'd1);
    tick(); drv(1, 1, 32'h66666666, 0, 0, 0, 32'h77777777); @(negedge clk);
    chk("t6_d_done", {31'd0, dut.d_done}, 32'd0);
    chk("t6_load_pass", load_data_o, 32'h77777777);
    idle_cycle();
    chk("t6_count", stall_cycles, 32'd2);

    // saturation from a preloaded count
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    preload = 1;
    #1;
    release dut.stall_cnt_q;
    tick();
    preload = 0;
    @(negedge clk);
    chk("t7_preload", stall_cycles, 32'hFFFF_FFFE);
    for (int c = 0; c < 4; c++) begin
      tick();
      drv(1, c == 3, (c == 3) ? 32'h99999999 : G, 0, 0, 0, G);
      @(negedge clk);
      if (c >= 1) chk("t7_sat", stall_cycles, 32'hFFFF_FFFF);
    end
    idle_cycle();
    chk("t7_sat_final", stall_cycles, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
